uart_cmd_parser: RTL and testbench

//  Sequences the byte stream from the UART receiver into PID configuration writes.

---
 rtl/uart_cmd_parser.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// UART command parser: frames SYNC/ADDR/DATA_H/DATA_L/CHK byte sequences from the
// receiver into single-cycle config register writes, rejecting bad or stalled frames.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned ADDR_W    = 2,
    parameter logic [15:0] TIMEOUT   = 16'd4000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_rdy,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [15:0]       cfg_wdata,
    output logic              frame_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    // One bit wider than the address byte so NUM_REGS up to 256 compares cleanly
    localparam logic [8:0] NumRegsW = 9'(NUM_REGS);

    typedef enum logic [2:0] {StIdle, StAddr, StDataH, StDataL, StChk} state_e;

    state_e            state_q, state_d;
    logic              rx_rdy_q;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        dh_q, dh_d;
    logic [7:0]        dl_q, dl_d;
    logic [15:0]       tmo_q, tmo_d;
    logic              cfg_we_q, cfg_we_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic [15:0]       cfg_wdata_q, cfg_wdata_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic byte_stb;
    logic chk_ok;
    logic timeout_hit;
    logic err_inc;

    assign byte_stb    = rx_rdy & ~rx_rdy_q;
    assign chk_ok      = (rx_byte == (addr_q ^ dh_q ^ dl_q)) && ({1'b0, addr_q} < NumRegsW);
    // A byte arriving in the same cycle as expiry takes priority over the timeout
    assign timeout_hit = (state_q != StIdle) && !byte_stb && (tmo_q == TIMEOUT - 16'd1);

    // State and output registers; rx_rdy_q resets high so a level already up is not a byte
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= StIdle;
            rx_rdy_q    <= 1'b1;
            addr_q      <= '0;
            dh_q        <= '0;
            dl_q        <= '0;
            tmo_q       <= '0;
            cfg_we_q    <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rx_rdy_q    <= rx_rdy;
            addr_q      <= addr_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            tmo_q       <= tmo_d;
            cfg_we_q    <= cfg_we_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Frame sequencing, inter-byte timeout and write/error strobe generation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        cfg_we_d    = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        err_inc     = 1'b0;

        if (state_q == StIdle || byte_stb) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        if (byte_stb) begin
            case (state_q)
                StIdle: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = StAddr;
                    end
                end
                StAddr: begin
                    addr_d  = rx_byte;
                    state_d = StDataH;
                end
                StDataH: begin
                    dh_d    = rx_byte;
                    state_d = StDataL;
                end
                StDataL: begin
                    dl_d    = rx_byte;
                    state_d = StChk;
                end
                StChk: begin
                    state_d = StIdle;
                    if (chk_ok) begin
                        cfg_we_d    = 1'b1;
                        cfg_addr_d  = addr_q[ADDR_W-1:0];
                        cfg_wdata_d = {dh_q, dl_q};
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout_hit) begin
            state_d = StIdle;
            tmo_d   = '0;
            err_inc = 1'b1;
        end

        frame_err_d = err_inc;
        err_cnt_d   = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign cfg_we    = cfg_we_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized traffic
// scored against a frame-level reference model with per-cycle event timing.
module tb_uart_cmd_parser;

    localparam int T = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_rdy;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    uart_cmd_parser #(
        .SYNC_BYTE (8'hA5),
        .NUM_REGS  (4),
        .ADDR_W    (2),
        .TIMEOUT   (16'(T))
    ) dut (
        .clk_in    (clk),
        .reset     (reset),
        .rx_byte   (rx_byte),
        .rx_rdy    (rx_rdy),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          err;
        logic [1:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Output events observed mid-cycle, tagged with the edge that launched them
    always @(negedge clk) begin
        ev_t e;
        if (cfg_we === 1'b1) begin
            e.cyc = cyc; e.err = 1'b0; e.addr = cfg_addr; e.data = cfg_wdata;
            obs_q.push_back(e);
        end
        if (frame_err === 1'b1) begin
            e.cyc = cyc; e.err = 1'b1; e.addr = '0; e.data = '0;
            obs_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference model state: frame-level view of the protocol
    bit          m_in = 1'b0;
    logic [7:0]  m_buf[$];
    int          m_last = 0;
    int          m_errcnt = 0;
    logic [1:0]  m_addr = '0;
    logic [15:0] m_data = '0;

    function automatic void m_err(input int at);
        ev_t e;
        e.cyc = at; e.err = 1'b1; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
        if (m_errcnt < 255) m_errcnt++;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int at);
        ev_t e;
        if (m_in && (at - m_last) > T) begin
            m_err(m_last + T);
            m_in = 1'b0;
        end
        if (!m_in) begin
            if (b == 8'hA5) begin
                m_in = 1'b1;
                m_buf.delete();
            end
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                m_in = 1'b0;
                if (m_buf[3] == (m_buf[0] ^ m_buf[1] ^ m_buf[2]) && m_buf[0] < 8'd4) begin
                    m_addr = m_buf[0][1:0];
                    m_data = {m_buf[1], m_buf[2]};
                    e.cyc = at; e.err = 1'b0; e.addr = m_addr; e.data = m_data;
                    exp_q.push_back(e);
                end else begin
                    m_err(at);
                end
            end
        end
        m_last = at;
    endfunction

    function automatic void model_flush(input int now);
        if (m_in && (now - m_last) >= T) begin
            m_err(m_last + T);
            m_in = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise rx_rdy so the strobe lands 'gap' edges after the previous one
    task automatic send_byte(input logic [7:0] b, input int gap);
        int target;
        target = m_last + gap - 1;
        while (cyc < target) step();
        rx_byte = b;
        rx_rdy  = 1'b1;
        step();
        model_byte(b, cyc);
        @(negedge clk);
        check("busy_after_byte", {31'b0, busy}, {31'b0, m_in});
        step();
        step();
        rx_rdy  = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
        send_byte(b0, $urandom_range(4, 30));
        send_byte(b1, $urandom_range(4, 30));
        send_byte(b2, $urandom_range(4, 30));
        send_byte(b3, $urandom_range(4, 30));
        send_byte(b4, $urandom_range(4, 30));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
        model_flush(cyc);
    endtask

    task automatic compare_events();
        int n;
        @(negedge clk);
        check("event_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("event_cycle", obs_q[i].cyc, exp_q[i].cyc);
            check("event_kind", {31'b0, obs_q[i].err}, {31'b0, exp_q[i].err});
            if (!exp_q[i].err) begin
                check("write_addr", {30'b0, obs_q[i].addr}, {30'b0, exp_q[i].addr});
                check("write_data", {16'b0, obs_q[i].data}, {16'b0, exp_q[i].data});
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic end_check();
        compare_events();
        check("err_cnt", {24'b0, err_cnt}, m_errcnt);
        check("cfg_addr_hold", {30'b0, cfg_addr}, {30'b0, m_addr});
        check("cfg_wdata_hold", {16'b0, cfg_wdata}, {16'b0, m_data});
        check("busy", {31'b0, busy}, {31'b0, m_in});
    endtask

    // Synchronous reset, optionally with rx_rdy held high across release
    task automatic do_reset(input bit hold_rdy);
        reset   = 1'b1;
        rx_rdy  = hold_rdy;
        rx_byte = 8'hA5;
        step();
        step();
        reset = 1'b0;
        m_in = 1'b0; m_buf.delete(); m_errcnt = 0; m_addr = '0; m_data = '0;
        step();
        step();
        step();
        rx_rdy = 1'b0;
        step();
        m_last = cyc;
        end_check();
    endtask

    task automatic random_frame();
        logic [7:0] a, dh, dl, c, nz;
        int r;
        repeat ($urandom_range(0, 2)) begin
            nz = 8'($urandom);
            if (nz == 8'hA5) nz = 8'h5A;
            send_byte(nz, $urandom_range(4, 30));
        end
        a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
        dh = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
        dl = 8'($urandom);
        c  = a ^ dh ^ dl;
        if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
        r = $urandom_range(0, 29);
        if (r == 0) begin
            send_byte(8'hA5, $urandom_range(4, 30));
            send_byte(a, $urandom_range(4, 30));
            idle(T + 2);
        end else begin
            send5(8'hA5, a, dh, dl, c);
        end
        end_check();
    endtask

    initial begin
        reset   = 1'b1;
        rx_rdy  = 1'b0;
        rx_byte = 8'h00;
        step();
        step();
        reset = 1'b0;
        step();
        m_last = cyc;
        @(negedge clk);
        check("rst_cfg_we", {31'b0, cfg_we}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cfg_addr", {30'b0, cfg_addr}, 32'd0);
        check("rst_cfg_wdata", {16'b0, cfg_wdata}, 32'd0);
        step();

        // Valid frame, bad checksum, out-of-range address, leading noise
        send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
        end_check();
        check("t1_addr", {30'b0, cfg_addr}, 32'd1);
        check("t1_wdata", {16'b0, cfg_wdata}, 32'h1234);
        send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h28);
        end_check();
        check("t2_err_cnt", {24'b0, err_cnt}, 32'd1);
        send5(8'hA5, 8'h07, 8'h00, 8'h05, 8'h02);
        end_check();
        send_byte(8'h00, 6);
        send_byte(8'hFF, 6);
        send5(8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65);
        end_check();
        check("t4_wdata", {16'b0, cfg_wdata}, 32'hABCD);

        // SYNC value inside a frame is plain data
        send5(8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00);
        end_check();

        // Timeout mid-frame, then recovery
        send_byte(8'hA5, 6);
        send_byte(8'h02, 6);
        idle(T + 5);
        end_check();
        send5(8'hA5, 8'h02, 8'hBE, 8'hEF, 8'h53);
        end_check();

        // Byte exactly at the timeout edge wins; one edge later it is too late
        send_byte(8'hA5, 8);
        send_byte(8'h01, T);
        send_byte(8'h55, 8);
        send_byte(8'h66, 8);
        send_byte(8'h32, T + 1);
        end_check();

        // Reset mid-frame, with rx_rdy held high through release
        send_byte(8'hA5, 6);
        send_byte(8'h01, 6);
        send_byte(8'h12, 6);
        do_reset(1'b1);
        send5(8'hA5, 8'h00, 8'h00, 8'h01, 8'h01);
        end_check();
        check("t6_wdata", {16'b0, cfg_wdata}, 32'h0001);

        // Error counter saturation
        repeat (260) begin
            send_byte(8'hA5, $urandom_range(4, 6));
            send_byte(8'h01, $urandom_range(4, 6));
            send_byte(8'h02, $urandom_range(4, 6));
            send_byte(8'h03, $urandom_range(4, 6));
            send_byte(8'hFF, $urandom_range(4, 6));
        end
        end_check();
        check("err_cnt_sat", {24'b0, err_cnt}, 32'hFF);
        do_reset(1'b0);

        repeat (120) random_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
